// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - matrix row write bus into systolic_feeder
interface systolic_feeder_if #(
  parameter int DATA_W = 32
);
  logic                wr_en_i;
  logic                wr_sel_i;
  logic [1:0]          wr_row_i;
  logic [4*DATA_W-1:0] wr_data_i;

  modport master (output wr_en_i, wr_sel_i, wr_row_i, wr_data_i);
  modport slave  (input  wr_en_i, wr_sel_i, wr_row_i, wr_data_i);
endinterface

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skewed operand feeder for the 4x4 systolic array (option: SYSTOLIC_FEEDER_TRANSPOSE_B_EN)
module systolic_feeder #(
  parameter int DATA_W    = 32,
  parameter int DRAIN_CYC = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  systolic_feeder_if.slave  wr_bus,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] left_o_0,
  output logic [DATA_W-1:0] left_o_4,
  output logic [DATA_W-1:0] left_o_8,
  output logic [DATA_W-1:0] left_o_12,
  output logic [DATA_W-1:0] up_o_0,
  output logic [DATA_W-1:0] up_o_1,
  output logic [DATA_W-1:0] up_o_2,
  output logic [DATA_W-1:0] up_o_3
);

  localparam logic [3:0] LAST_STEP = 4'd9;   // 3N-2 steps, k = 0..9
  localparam int         CNT_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [CNT_W-1:0]  drain_q, drain_d;
  logic              busy_d, done_d;

  logic [DATA_W-1:0] mat_a [4][4];
  logic [DATA_W-1:0] mat_b [4][4];

  logic [DATA_W-1:0] left_q [4];
  logic [DATA_W-1:0] up_q   [4];
  logic [DATA_W-1:0] left_d [4];
  logic [DATA_W-1:0] up_d   [4];

  logic              load_en;
  logic [3:0]        step;
  logic [3:0]        left_idx [4];
  logic [3:0]        up_idx   [4];
  logic              wr_accept;

  // Writes only land while idle and not being pre-empted by a start.
  assign wr_accept = (state_q == IDLE) && !start_i && wr_bus.wr_en_i;

  assign left_o_0  = left_q[0];
  assign left_o_4  = left_q[1];
  assign left_o_8  = left_q[2];
  assign left_o_12 = left_q[3];
  assign up_o_0    = up_q[0];
  assign up_o_1    = up_q[1];
  assign up_o_2    = up_q[2];
  assign up_o_3    = up_q[3];

  // Operand storage: one row (or B column in transpose mode) per accepted write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          mat_a[i][j] <= '0;
          mat_b[i][j] <= '0;
        end
      end
    end else if (wr_accept) begin
      for (int j = 0; j < 4; j++) begin
        if (!wr_bus.wr_sel_i) begin
          mat_a[wr_bus.wr_row_i][j] <= wr_bus.wr_data_i[j*DATA_W +: DATA_W];
        end else begin
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
          mat_b[j][wr_bus.wr_row_i] <= wr_bus.wr_data_i[j*DATA_W +: DATA_W];
`else
          mat_b[wr_bus.wr_row_i][j] <= wr_bus.wr_data_i[j*DATA_W +: DATA_W];
`endif
        end
      end
    end
  end

  // State register plus the registered status and wavefront outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      drain_q <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        left_q[i] <= '0;
        up_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
      for (int i = 0; i < 4; i++) begin
        left_q[i] <= left_d[i];
        up_q[i]   <= up_d[i];
      end
    end
  end

  // Next-state logic: step counter walks the wavefronts, drain counter waits out the array.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        if (k_q == LAST_STEP) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: pick the step whose skewed values load at this edge, zero elsewhere.
  always_comb begin
    busy_d  = busy_o;
    done_d  = 1'b0;
    load_en = 1'b0;
    step    = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          busy_d  = 1'b1;
          load_en = 1'b1;
          step    = '0;
        end
      end
      STREAM: begin
        if (k_q != LAST_STEP) begin
          load_en = 1'b1;
          step    = k_q + 4'd1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          done_d = 1'b1;
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase

    for (int r = 0; r < 4; r++) begin
      left_idx[r] = step - 4'(r);
      up_idx[r]   = step - 4'(r);
      left_d[r]   = (load_en && (step >= 4'(r)) && (left_idx[r] <= 4'd3))
                    ? mat_a[r][left_idx[r][1:0]] : '0;
      up_d[r]     = (load_en && (step >= 4'(r)) && (up_idx[r] <= 4'd3))
                    ? mat_b[up_idx[r][1:0]][r] : '0;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder
module tb_systolic_feeder;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] left_o_0, left_o_4, left_o_8, left_o_12;
  logic [31:0] up_o_0, up_o_1, up_o_2, up_o_3;

  systolic_feeder_if #(.DATA_W(32)) wr_if ();

  systolic_feeder #(.DATA_W(32), .DRAIN_CYC(7)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_bus    (wr_if),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .left_o_0  (left_o_0),
    .left_o_4  (left_o_4),
    .left_o_8  (left_o_8),
    .left_o_12 (left_o_12),
    .up_o_0    (up_o_0),
    .up_o_1    (up_o_1),
    .up_o_2    (up_o_2),
    .up_o_3    (up_o_3)
  );

  logic [31:0] lo [4];
  logic [31:0] uo [4];
  assign lo[0] = left_o_0;
  assign lo[1] = left_o_4;
  assign lo[2] = left_o_8;
  assign lo[3] = left_o_12;
  assign uo[0] = up_o_0;
  assign uo[1] = up_o_1;
  assign uo[2] = up_o_2;
  assign uo[3] = up_o_3;

  int checks = 0;
  int errors = 0;

  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];
  logic [31:0] snap_l [10][4];
  logic [31:0] snap_u [10][4];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] exp_left(int r, int k);
    int d = k - r;
    if (d >= 0 && d <= 3) return ma[r][d];
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_up(int c, int k);
    int d = k - c;
    if (d >= 0 && d <= 3) return mb[d][c];
    return 32'd0;
  endfunction

  task automatic wr_row(input logic sel, input logic [1:0] row,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    wr_if.wr_en_i   = 1'b1;
    wr_if.wr_sel_i  = sel;
    wr_if.wr_row_i  = row;
    wr_if.wr_data_i = {d3, d2, d1, d0};
    tick();
    wr_if.wr_en_i   = 1'b0;
  endtask

  // Pushes the bench copies ma/mb into the DUT in the write layout of this build.
  task automatic load_mats();
    for (int r = 0; r < 4; r++)
      wr_row(1'b0, 2'(r), ma[r][0], ma[r][1], ma[r][2], ma[r][3]);
    for (int r = 0; r < 4; r++) begin
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
      wr_row(1'b1, 2'(r), mb[0][r], mb[1][r], mb[2][r], mb[3][r]);
`else
      wr_row(1'b1, 2'(r), mb[r][0], mb[r][1], mb[r][2], mb[r][3]);
`endif
    end
  endtask

  // One full stream: per-step check of all 8 outputs, then done timing.
  // inject=1 writes 9s into A row 0 mid-stream and pulses start mid-stream.
  task automatic run_stream(input string tag, input bit inject);
    int edges;
    int dones;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        if (inject && k == 4) begin
          wr_if.wr_en_i   = 1'b1;
          wr_if.wr_sel_i  = 1'b0;
          wr_if.wr_row_i  = 2'd0;
          wr_if.wr_data_i = {32'd9, 32'd9, 32'd9, 32'd9};
        end
        if (inject && k == 6) start_i = 1'b1;
        tick();
        wr_if.wr_en_i = 1'b0;
        start_i       = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        snap_l[k][i] = lo[i];
        snap_u[k][i] = uo[i];
        check($sformatf("%s left r%0d k%0d", tag, i, k), lo[i], exp_left(i, k));
        check($sformatf("%s up c%0d k%0d", tag, i, k), uo[i], exp_up(i, k));
      end
      check($sformatf("%s busy k%0d", tag, k), {31'd0, busy_o}, 32'd1);
    end
    edges = 9;
    dones = 0;
    while (dones == 0 && edges < 60) begin
      tick();
      edges++;
      if (done_o) dones++;
    end
    check({tag, " done edge"}, edges, 32'd17);
    check({tag, " busy at done"}, {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o) dones++;
    end
    check({tag, " done pulses"}, dones, 32'd1);
    check({tag, " busy after"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_i           = 1'b1;
    start_i         = 1'b0;
    wr_if.wr_en_i   = 1'b0;
    wr_if.wr_sel_i  = 1'b0;
    wr_if.wr_row_i  = 2'd0;
    wr_if.wr_data_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset left %0d", i), lo[i], 32'd0);
      check($sformatf("reset up %0d", i), uo[i], 32'd0);
    end
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);

    // Identity matrices.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = (r == c) ? 32'd1 : 32'd0;
        mb[r][c] = (r == c) ? 32'd1 : 32'd0;
      end
    load_mats();
    run_stream("ident", 1'b0);
    check("ident k0 left0", snap_l[0][0], 32'd1);
    check("ident k0 up0", snap_u[0][0], 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("ident k3 left %0d", i), snap_l[3][i], 32'd0);
    check("ident k6 left12", snap_l[6][3], 32'd1);
    check("ident k6 up3", snap_u[6][3], 32'd1);
    check("ident k7 up3", snap_u[7][3], 32'd0);

    // Numbered matrices: A = 4r+c+1, B = 17+4r+c.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 32'(4*r + c + 1);
        mb[r][c] = 32'(17 + 4*r + c);
      end
    load_mats();
    run_stream("ramp", 1'b0);
    check("ramp k0 left0", snap_l[0][0], 32'd1);
    check("ramp k0 up0", snap_u[0][0], 32'd17);
    check("ramp k3 left0", snap_l[3][0], 32'd4);
    check("ramp k3 left12", snap_l[3][3], 32'd13);
    check("ramp k3 up3", snap_u[3][3], 32'd20);
    check("ramp k6 left12", snap_l[6][3], 32'd16);
    check("ramp k6 up3", snap_u[6][3], 32'd32);
    check("ramp k9 left12", snap_l[9][3], 32'd0);

    // Write and start during busy are ignored; next run streams old row 0.
    run_stream("inject", 1'b1);
    run_stream("after", 1'b0);
    check("after k1 left0", snap_l[1][0], 32'd2);
    check("after k3 left0", snap_l[3][0], 32'd4);

    // Reset mid-stream at k=4.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    check("pre-reset busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midrst left %0d", i), lo[i], 32'd0);
      check($sformatf("midrst up %0d", i), uo[i], 32'd0);
    end
    check("midrst busy", {31'd0, busy_o}, 32'd0);
    check("midrst done", {31'd0, done_o}, 32'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 32'd0;
        mb[r][c] = 32'd0;
      end
    run_stream("zeros", 1'b0);

    // Single B write of {5,6,7,8} to index 2.
    wr_row(1'b1, 2'd2, 32'd5, 32'd6, 32'd7, 32'd8);
    for (int j = 0; j < 4; j++) begin
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
      mb[j][2] = 32'(5 + j);
`else
      mb[2][j] = 32'(5 + j);
`endif
    end
    run_stream("bwrite", 1'b0);
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
    check("bcol k2 up2", snap_u[2][2], 32'd5);
    check("bcol k5 up2", snap_u[5][2], 32'd8);
`else
    check("brow k2 up2", snap_u[2][2], 32'd0);
    check("brow k4 up2", snap_u[4][2], 32'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
